// File: rtl/plot_receiver_if.sv
// Pixel-plot command bus and raster scan-out port of plot_receiver.
// slave is the receiver side; master is the renderer / scan consumer side.
interface plot_receiver_if;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic       plot_ready;
    logic       overflow;
    logic       init_done;
    logic       scan_start;
    logic       scan_busy;
    logic       scan_valid;
    logic       scan_ready;
    logic [7:0] scan_x;
    logic [6:0] scan_y;
    logic [2:0] scan_colour;
    logic       scan_last;

    modport master (
        output vga_x, vga_y, vga_colour, vga_plot, scan_start, scan_ready,
        input  plot_ready, overflow, init_done, scan_busy, scan_valid,
               scan_x, scan_y, scan_colour, scan_last
    );
    modport slave (
        input  vga_x, vga_y, vga_colour, vga_plot, scan_start, scan_ready,
        output plot_ready, overflow, init_done, scan_busy, scan_valid,
               scan_x, scan_y, scan_colour, scan_last
    );
endinterface

// File: rtl/plot_receiver.sv
// Plot FIFO + 160x120x3 framebuffer + raster scan-out engine.
// Optional power-on clear sweep: define PLOT_RECEIVER_FB_CLEAR_EN.
module plot_receiver #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    plot_receiver_if.slave bus
);
    localparam int          PTR_W     = $clog2(FIFO_DEPTH);
    localparam int          CNT_W     = PTR_W + 1;
    localparam logic [14:0] LAST_ADDR = 15'd19199;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] colour;
    } plot_cmd_t;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN_OUT} scan_state_t;

    logic        init_done;
    logic        clearing;
    logic [14:0] clr_addr;

`ifdef PLOT_RECEIVER_FB_CLEAR_EN
    logic init_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_addr <= '0;
            init_q   <= 1'b0;
        end else if (!init_q) begin
            clr_addr <= clr_addr + 15'd1;
            if (clr_addr == LAST_ADDR) init_q <= 1'b1;
        end
    end
    assign init_done = init_q;
    assign clearing  = !init_q;
`else
    assign clr_addr  = '0;
    assign init_done = 1'b1;
    assign clearing  = 1'b0;
`endif

    // ---------------- plot FIFO ----------------
    plot_cmd_t        fifo_mem [FIFO_DEPTH];
    plot_cmd_t        head;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             in_range, full, push, pop, drop, overflow;

    assign in_range = (bus.vga_x < 8'd160) && (bus.vga_y < 7'd120);
    assign full     = (count == CNT_W'(FIFO_DEPTH));
    assign pop      = (count != '0) && init_done;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push     = bus.vga_plot && in_range && (!full || pop);
    assign drop     = bus.vga_plot && in_range && full && !pop;
    assign head     = fifo_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= plot_cmd_t'{bus.vga_x, bus.vga_y, bus.vga_colour};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (drop) overflow <= 1'b1;
        end
    end

    assign bus.plot_ready = !full && init_done;
    assign bus.overflow   = overflow;
    assign bus.init_done  = init_done;

    // ---------------- framebuffer ----------------
    logic [2:0]  fb [19200];
    logic [14:0] head_y15, plot_addr, waddr;
    logic [2:0]  wdata;
    logic        we;

    assign head_y15  = {8'd0, head.y};
    assign plot_addr = (head_y15 << 7) + (head_y15 << 5) + {7'd0, head.x};
    assign we        = clearing || pop;
    assign waddr     = clearing ? clr_addr : plot_addr;
    assign wdata     = clearing ? 3'd0 : head.colour;

    always_ff @(posedge clk) begin
        if (we) fb[waddr] <= wdata;
    end

    // ---------------- raster scan ----------------
    scan_state_t state;
    logic [14:0] scan_addr;
    logic [7:0]  sx, scan_x;
    logic [6:0]  sy, scan_y;
    logic [2:0]  scan_colour;
    logic        scan_busy, scan_valid, scan_last, read_en;

    // The RAM read register doubles as the output register, so a read is
    // only issued when that register is empty or being handed off.
    assign read_en = (state == RUN) && (!scan_valid || bus.scan_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            scan_addr   <= '0;
            sx          <= '0;
            sy          <= '0;
            scan_busy   <= 1'b0;
            scan_valid  <= 1'b0;
            scan_last   <= 1'b0;
            scan_x      <= '0;
            scan_y      <= '0;
            scan_colour <= '0;
        end else begin
            if (scan_valid && bus.scan_ready) scan_valid <= 1'b0;
            case (state)
                IDLE: if (bus.scan_start && init_done) begin
                    state     <= RUN;
                    scan_busy <= 1'b1;
                    scan_addr <= '0;
                    sx        <= '0;
                    sy        <= '0;
                end
                RUN: if (read_en) begin
                    scan_valid  <= 1'b1;
                    scan_x      <= sx;
                    scan_y      <= sy;
                    scan_colour <= fb[scan_addr];
                    scan_last   <= (scan_addr == LAST_ADDR);
                    scan_addr   <= scan_addr + 15'd1;
                    if (sx == 8'd159) begin
                        sx <= '0;
                        sy <= sy + 7'd1;
                    end else begin
                        sx <= sx + 8'd1;
                    end
                    if (scan_addr == LAST_ADDR) state <= DRAIN_OUT;
                end
                DRAIN_OUT: if (scan_valid && bus.scan_ready && scan_last) begin
                    state     <= IDLE;
                    scan_busy <= 1'b0;
                    scan_last <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.scan_busy   = scan_busy;
    assign bus.scan_valid  = scan_valid;
    assign bus.scan_x      = scan_x;
    assign bus.scan_y      = scan_y;
    assign bus.scan_colour = scan_colour;
    assign bus.scan_last   = scan_last;
endmodule

// File: tb/tb_plot_receiver.sv
// Directed bench for plot_receiver: plot vector table, full raster scans
// against a reference image, stall stability, reset mid-scan.
module tb_plot_receiver;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    plot_receiver_if bus ();
    plot_receiver #(.FIFO_DEPTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        bit         keep;
    } vec_t;

    vec_t       vecs [8];
    logic [2:0] fbm [19200];
    int         n_cmp = 0;
    int         n_fail = 0;
    logic [2:0] c485, c1010;
    bit         exp_ovf = 1'b0;

`ifdef PLOT_RECEIVER_FB_CLEAR_EN
    localparam logic INIT_EXP = 1'b0;
`else
    localparam logic INIT_EXP = 1'b1;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Starts a scan and consumes stop_after pixels, checking order, data and stalls.
    task automatic run_scan(input bit toggle, input int stop_after, input bit chk_col);
        int hs = 0, cyc = 0, e_xy = 0, e_col = 0, e_last = 0, e_stab = 0;
        logic [7:0] px;
        logic [6:0] py;
        logic [2:0] pc;
        logic pl;
        bit pv = 1'b0, pr = 1'b0;
        bus.scan_ready = 1'b0;
        bus.scan_start = 1'b1;
        tick();
        bus.scan_start = 1'b0;
        bus.vga_plot   = 1'b0;
        chk("busy_rise", bus.scan_busy, 1);
        chk("valid_not_yet", bus.scan_valid, 0);
        tick();
        chk("first_valid", bus.scan_valid, 1);
        chk("first_xy", {bus.scan_x, bus.scan_y}, 0);
        while (hs < stop_after && cyc < 39000) begin
            bus.scan_ready = toggle ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
            if (pv && !pr && (bus.scan_valid !== 1'b1 || bus.scan_x !== px || bus.scan_y !== py ||
                              bus.scan_colour !== pc || bus.scan_last !== pl))
                e_stab++;
            if (bus.scan_valid && bus.scan_ready) begin
                if (int'(bus.scan_x) != hs % 160 || int'(bus.scan_y) != hs / 160) e_xy++;
                if (chk_col && bus.scan_colour !== fbm[hs]) e_col++;
                if (bus.scan_last !== (hs == 19199)) e_last++;
                if (hs == 485) c485 = bus.scan_colour;
                if (hs == 1610) c1010 = bus.scan_colour;
                hs++;
            end
            pv = bus.scan_valid;
            pr = bus.scan_ready;
            px = bus.scan_x;
            py = bus.scan_y;
            pc = bus.scan_colour;
            pl = bus.scan_last;
            tick();
            cyc++;
        end
        chk("scan_handshakes", hs, stop_after);
        chk("scan_xy_errors", e_xy, 0);
        chk("scan_colour_errors", e_col, 0);
        chk("scan_last_errors", e_last, 0);
        chk("scan_stall_errors", e_stab, 0);
        if (stop_after == 19200) begin
            chk("busy_fall", bus.scan_busy, 0);
            chk("valid_after_last", bus.scan_valid, 0);
        end
    endtask

    initial begin
        int n, err;
        vecs[0] = '{8'd5,   7'd3,   3'd6, 1'b1};
        vecs[1] = '{8'd160, 7'd0,   3'd7, 1'b0};
        vecs[2] = '{8'd0,   7'd120, 3'd5, 1'b0};
        vecs[3] = '{8'd10,  7'd10,  3'd1, 1'b1};
        vecs[4] = '{8'd10,  7'd10,  3'd4, 1'b1};
        vecs[5] = '{8'd159, 7'd119, 3'd2, 1'b1};
        vecs[6] = '{8'd255, 7'd127, 3'd1, 1'b0};
        vecs[7] = '{8'd0,   7'd0,   3'd3, 1'b1};
        for (int i = 0; i < 19200; i++) fbm[i] = 3'd0;
        bus.vga_x = '0; bus.vga_y = '0; bus.vga_colour = '0; bus.vga_plot = 1'b0;
        bus.scan_start = 1'b0; bus.scan_ready = 1'b0;

        #12;
        chk("rst_plot_ready", bus.plot_ready, INIT_EXP);
        chk("rst_init_done", bus.init_done, INIT_EXP);
        chk("rst_overflow", bus.overflow, 0);
        chk("rst_scan_busy", bus.scan_busy, 0);
        chk("rst_scan_valid", bus.scan_valid, 0);
        chk("rst_scan_last", bus.scan_last, 0);
        chk("rst_scan_x", bus.scan_x, 0);
        chk("rst_scan_y", bus.scan_y, 0);
        chk("rst_scan_colour", bus.scan_colour, 0);
        #3 rst_n = 1'b1;

`ifdef PLOT_RECEIVER_FB_CLEAR_EN
        n = 0;
        for (int i = 0; i < 9; i++) begin
            bus.vga_x = 8'(i * 7); bus.vga_y = 7'(i + 1); bus.vga_colour = 3'(i % 7 + 1);
            bus.vga_plot = 1'b1;
            if (i < 8) fbm[(i + 1) * 160 + i * 7] = 3'(i % 7 + 1);
            tick();
            n++;
            chk("sweep_plot_ready", bus.plot_ready, 0);
            if (i == 7) chk("ovf_before_9th", bus.overflow, 0);
        end
        bus.vga_plot = 1'b0;
        chk("ovf_9th", bus.overflow, 1);
        while (!bus.init_done && n < 20000) begin
            tick();
            n++;
        end
        chk("init_cycles", n, 19200);
        exp_ovf = 1'b1;
        repeat (10) tick();
`else
        tick();
        err = 0;
        for (int y = 0; y < 120; y++) begin
            for (int x = 0; x < 160; x++) begin
                bus.vga_x = 8'(x); bus.vga_y = 7'(y); bus.vga_colour = 3'((x + 2 * y + 1) % 8);
                bus.vga_plot = 1'b1;
                fbm[y * 160 + x] = 3'((x + 2 * y + 1) % 8);
                tick();
                if (bus.plot_ready !== 1'b1 || bus.overflow !== 1'b0) err++;
            end
        end
        chk("fill_flow_errors", err, 0);
`endif

        for (int i = 0; i < 8; i++) begin
            bus.vga_x = vecs[i].x; bus.vga_y = vecs[i].y; bus.vga_colour = vecs[i].c;
            bus.vga_plot = 1'b1;
            tick();
            chk($sformatf("vec%0d_plot_ready", i), bus.plot_ready, 1);
            chk($sformatf("vec%0d_overflow", i), bus.overflow, exp_ovf);
            if (vecs[i].keep) fbm[int'(vecs[i].y) * 160 + int'(vecs[i].x)] = vecs[i].c;
        end
        bus.vga_plot = 1'b0;
        repeat (4) tick();

        // Plot issued alongside scan_start lands well before its address is read.
        bus.vga_x = 8'd100; bus.vga_y = 7'd119; bus.vga_colour = 3'd7; bus.vga_plot = 1'b1;
        fbm[119 * 160 + 100] = 3'd7;
        run_scan(1'b1, 19200, 1'b1);
        chk("px485_colour", c485, 6);
        chk("px10_10_colour", c1010, 4);
        chk("ovf_after_scan", bus.overflow, exp_ovf);

        run_scan(1'b0, 1000, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_scan_valid", bus.scan_valid, 0);
        chk("midrst_scan_busy", bus.scan_busy, 0);
        chk("midrst_overflow", bus.overflow, 0);
        #1 rst_n = 1'b1;
        tick();
`ifdef PLOT_RECEIVER_FB_CLEAR_EN
        n = 0;
        while (!bus.init_done && n < 20000) begin
            tick();
            n++;
        end
        chk("reinit_done", bus.init_done, 1);
`endif
        run_scan(1'b0, 3, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
